sa_b_channel: RTL and testbench

SA_B_CHANNEL -- requirements
Module: sa_b_channel

---
 rtl/sa_b_channel_pkg.sv | 32 +++
 rtl/sa_b_channel_fifo.sv | 61 ++++++
 rtl/sa_b_channel.sv | 146 ++++++++++++++
 tb/tb_sa_b_channel.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_b_channel_pkg.sv
// Shared interconnect definitions: BRESP encodings, B-channel FSM states
// and the severity-ordered response merge used for 4KB-split writes.
package sa_b_channel_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        S_PASS  = 1'b0,
        S_MERGE = 1'b1
    } bMergeState_e;

    // Severity rank: DECERR > SLVERR > OKAY > EXOKAY
    function automatic logic [1:0] respRank(input logic [1:0] resp);
        case (resp)
            RESP_DECERR: return 2'd3;
            RESP_SLVERR: return 2'd2;
            RESP_OKAY:   return 2'd1;
            default:     return 2'd0;
        endcase
    endfunction

    // Combine the two halves of a split write into one response; EXOKAY
    // survives only when both halves were exclusive-okay.
    function automatic logic [1:0] bRespMerge(input logic [1:0] respA,
                                              input logic [1:0] respB);
        return (respRank(respA) >= respRank(respB)) ? respA : respB;
    endfunction

endpackage

// File: rtl/sa_b_channel_fifo.sv
// Small synchronous FIFO with registered write and combinational head read;
// a pushed entry becomes visible at the head on the following cycle.
module sa_b_channel_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  ACLK_i,
    input  logic                  ARESETn_i,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      count;
    logic                  doPush;
    logic                  doPop;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign doPush = wrEn & ~full;
    assign doPop  = rdEn & ~empty;
    assign rdData = mem[rdPtr];

    // Store accepted pushes into the slot addressed by the write pointer
    always_ff @(posedge ACLK_i) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Advance pointers and occupancy; push and pop together keep count steady
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_b_channel.sv
// Slave-side B channel: merges responses of 4KB-split write pairs, tracked
// by an AW order queue, and dispatches one-hot BVALID to the owning master.
module sa_b_channel
    import sa_b_channel_pkg::*;
#(
    parameter int MST_AMT         = 3,
    parameter int OUTSTANDING_AMT = 8,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int MST_ID_W        = $clog2(MST_AMT),
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                       ACLK_i,
    input  logic                       ARESETn_i,
    input  logic                       AW_order_wr_en_i,
    input  logic                       AW_split_first_i,
    output logic                       AW_order_full_o,
    input  logic [TRANS_SLV_ID_W-1:0]  s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0] s_BRESP_i,
    input  logic                       s_BVALID_i,
    output logic                       s_BREADY_o,
    output logic [TRANS_MST_ID_W-1:0]  dsp_BID_o,
    output logic [TRANS_WR_RESP_W-1:0] dsp_BRESP_o,
    output logic [MST_AMT-1:0]         dsp_BVALID_o,
    input  logic [MST_AMT-1:0]         dsp_BREADY_i
);

    localparam logic [MST_ID_W:0] MST_LIMIT = (MST_ID_W + 1)'(MST_AMT);

    logic                       orderFull;
    logic                       orderEmpty;
    logic                       headSplit;
    logic                       sHs;
    logic                       downHs;
    logic                       sReady;
    logic [MST_ID_W-1:0]        inMst;
    logic                       inMstOk;
    bMergeState_e               state;
    bMergeState_e               nextState;
    logic                       loadOut;
    logic                       captureMerge;
    logic [TRANS_WR_RESP_W-1:0] loadResp;
    logic [TRANS_WR_RESP_W-1:0] mergeResp;
    logic [MST_ID_W-1:0]        outMst;
    logic [TRANS_MST_ID_W-1:0]  outId;
    logic [TRANS_WR_RESP_W-1:0] outResp;
    logic                       outValid;

    sa_b_channel_fifo #(
        .DATA_WIDTH (1),
        .FIFO_DEPTH (OUTSTANDING_AMT)
    ) orderFifo (
        .ACLK_i    (ACLK_i),
        .ARESETn_i (ARESETn_i),
        .wrEn      (AW_order_wr_en_i),
        .wrData    (AW_split_first_i),
        .rdEn      (sHs),
        .rdData    (headSplit),
        .full      (orderFull),
        .empty     (orderEmpty)
    );

    assign inMst   = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];
    assign inMstOk = ({1'b0, inMst} < MST_LIMIT);
    assign sReady  = ~orderEmpty & (~outValid | downHs);
    assign sHs     = s_BVALID_i & sReady;

    // Downstream handshake: the addressed master accepts the held response
    always_comb begin
        downHs = 1'b0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (outValid && (outMst == MST_ID_W'(i)) && dsp_BREADY_i[i]) begin
                downHs = 1'b1;
            end
        end
    end

    // Merge FSM state and first-half response register
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            state     <= S_PASS;
            mergeResp <= '0;
        end else begin
            state <= nextState;
            if (captureMerge) begin
                mergeResp <= s_BRESP_i;
            end
        end
    end

    // Decide per slave handshake whether to hold, merge or forward
    always_comb begin
        nextState    = state;
        loadOut      = 1'b0;
        captureMerge = 1'b0;
        loadResp     = s_BRESP_i;
        if (sHs) begin
            case (state)
                S_PASS: begin
                    if (headSplit) begin
                        captureMerge = 1'b1;
                        nextState    = S_MERGE;
                    end else begin
                        loadOut = 1'b1;
                    end
                end
                S_MERGE: begin
                    loadOut   = 1'b1;
                    loadResp  = bRespMerge(mergeResp, s_BRESP_i);
                    nextState = S_PASS;
                end
                default: nextState = S_PASS;
            endcase
        end
    end

    // Output register: a new load wins over clearing on downstream handshake;
    // responses for nonexistent masters are dropped here
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            outMst   <= '0;
            outId    <= '0;
            outResp  <= '0;
            outValid <= 1'b0;
        end else if (loadOut && inMstOk) begin
            outMst   <= inMst;
            outId    <= s_BID_i[TRANS_MST_ID_W-1:0];
            outResp  <= loadResp;
            outValid <= 1'b1;
        end else if (downHs) begin
            outValid <= 1'b0;
        end
    end

    // Drive outputs, forced low while reset is held
    always_comb begin
        for (int i = 0; i < MST_AMT; i++) begin
            dsp_BVALID_o[i] = ARESETn_i & outValid & (outMst == MST_ID_W'(i));
        end
        dsp_BID_o       = ARESETn_i ? outId : '0;
        dsp_BRESP_o     = ARESETn_i ? outResp : '0;
        s_BREADY_o      = ARESETn_i & sReady;
        AW_order_full_o = ARESETn_i & orderFull;
    end

endmodule

// File: tb/tb_sa_b_channel.sv
// Scoreboard bench for sa_b_channel: directed stimulus pushes expected
// dispatches into a queue, a negedge monitor pops and compares them.
module tb_sa_b_channel;

    typedef struct packed {
        logic [1:0] mst;
        logic [4:0] id;
        logic [1:0] resp;
    } bEntry_t;

    logic       ACLK_i = 1'b0;
    logic       ARESETn_i = 1'b0;
    logic       AW_order_wr_en_i = 1'b0;
    logic       AW_split_first_i = 1'b0;
    logic       AW_order_full_o;
    logic [6:0] s_BID_i = '0;
    logic [1:0] s_BRESP_i = '0;
    logic       s_BVALID_i = 1'b0;
    logic       s_BREADY_o;
    logic [4:0] dsp_BID_o;
    logic [1:0] dsp_BRESP_o;
    logic [2:0] dsp_BVALID_o;
    logic [2:0] dsp_BREADY_i = 3'b111;

    int assertCount = 0;
    int failCount = 0;
    bEntry_t sb[$];

    logic [1:0] pairFirst  [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
    logic [1:0] pairSecond [4] = '{2'b01, 2'b00, 2'b10, 2'b10};
    logic [1:0] pairExpect [4] = '{2'b01, 2'b00, 2'b11, 2'b10};

    sa_b_channel dut (
        .ACLK_i           (ACLK_i),
        .ARESETn_i        (ARESETn_i),
        .AW_order_wr_en_i (AW_order_wr_en_i),
        .AW_split_first_i (AW_split_first_i),
        .AW_order_full_o  (AW_order_full_o),
        .s_BID_i          (s_BID_i),
        .s_BRESP_i        (s_BRESP_i),
        .s_BVALID_i       (s_BVALID_i),
        .s_BREADY_o       (s_BREADY_o),
        .dsp_BID_o        (dsp_BID_o),
        .dsp_BRESP_o      (dsp_BRESP_o),
        .dsp_BVALID_o     (dsp_BVALID_o),
        .dsp_BREADY_i     (dsp_BREADY_i)
    );

    // 100 MHz clock
    always #5 ACLK_i = ~ACLK_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK_i);
        #1;
    endtask

    task automatic pushAw(input logic split);
        AW_order_wr_en_i = 1'b1;
        AW_split_first_i = split;
        tick();
        AW_order_wr_en_i = 1'b0;
        AW_split_first_i = 1'b0;
    endtask

    task automatic expectResp(input logic [1:0] mst, input logic [4:0] id,
                              input logic [1:0] resp);
        bEntry_t e;
        e.mst = mst;
        e.id = id;
        e.resp = resp;
        sb.push_back(e);
    endtask

    // Present one slave B beat and hold it until accepted (bounded)
    task automatic sendB(input logic [1:0] mst, input logic [4:0] id,
                         input logic [1:0] resp);
        int waitCycles = 0;
        s_BVALID_i = 1'b1;
        s_BID_i = {mst, id};
        s_BRESP_i = resp;
        #1;
        while (!s_BREADY_o && waitCycles < 100) begin
            @(posedge ACLK_i);
            #2;
            waitCycles++;
        end
        if (waitCycles >= 100) begin
            checkOutput("sendB_timeout", 32'(waitCycles), 32'd0);
        end
        tick();
        s_BVALID_i = 1'b0;
    endtask

    // Monitor: compare each downstream handshake against the scoreboard head
    // and require held responses to stay stable while stalled
    initial begin
        logic       prevHeld = 1'b0;
        logic [8:0] prevVal = '0;
        bEntry_t    e;
        logic [2:0] oneHot;
        forever begin
            @(negedge ACLK_i);
            if (ARESETn_i && dsp_BVALID_o != 3'b000) begin
                if (prevHeld) begin
                    checkOutput("held_stable", 32'({dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o}),
                                32'({prevVal[8:7] == 2'd0 ? 3'b001 :
                                     prevVal[8:7] == 2'd1 ? 3'b010 : 3'b100,
                                     prevVal[6:0]}));
                end
                if ((dsp_BVALID_o & dsp_BREADY_i) != 3'b000) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_resp", 32'({dsp_BVALID_o, dsp_BID_o}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        oneHot = 3'b001 << e.mst;
                        checkOutput("sb_bvalid", 32'(dsp_BVALID_o), 32'(oneHot));
                        checkOutput("sb_bid", 32'(dsp_BID_o), 32'(e.id));
                        checkOutput("sb_bresp", 32'(dsp_BRESP_o), 32'(e.resp));
                    end
                    prevHeld = 1'b0;
                end else begin
                    prevHeld = 1'b1;
                    prevVal = {(dsp_BVALID_o == 3'b001) ? 2'd0 :
                               (dsp_BVALID_o == 3'b010) ? 2'd1 : 2'd2,
                               dsp_BID_o, dsp_BRESP_o};
                end
            end else begin
                prevHeld = 1'b0;
            end
        end
    end

    task automatic applyStimulus();
        // Reset state
        ARESETn_i = 1'b0;
        repeat (3) tick();
        checkOutput("rst_bready", 32'(s_BREADY_o), 32'd0);
        checkOutput("rst_bvalid", 32'(dsp_BVALID_o), 32'd0);
        checkOutput("rst_bid", 32'(dsp_BID_o), 32'd0);
        checkOutput("rst_bresp", 32'(dsp_BRESP_o), 32'd0);
        checkOutput("rst_full", 32'(AW_order_full_o), 32'd0);
        ARESETn_i = 1'b1;
        tick();

        // Single pass-through response, one cycle latency
        pushAw(1'b0);
        expectResp(2'd1, 5'd5, 2'b00);
        sendB(2'd1, 5'd5, 2'b00);
        checkOutput("single_bvalid", 32'(dsp_BVALID_o), 32'b010);
        checkOutput("single_bid", 32'(dsp_BID_o), 32'd5);
        checkOutput("single_bresp", 32'(dsp_BRESP_o), 32'd0);
        tick();

        // Split pair OKAY + SLVERR collapses into one SLVERR
        pushAw(1'b1);
        pushAw(1'b0);
        expectResp(2'd2, 5'd7, 2'b10);
        sendB(2'd2, 5'd7, 2'b00);
        checkOutput("merge_first_quiet", 32'(dsp_BVALID_o), 32'd0);
        sendB(2'd2, 5'd7, 2'b10);
        checkOutput("merge_bvalid", 32'(dsp_BVALID_o), 32'b100);
        checkOutput("merge_bresp", 32'(dsp_BRESP_o), 32'b10);
        tick();

        // Merge severity table
        for (int i = 0; i < 4; i++) begin
            pushAw(1'b1);
            pushAw(1'b0);
            expectResp(2'd0, 5'(20 + i), pairExpect[i]);
            sendB(2'd0, 5'(20 + i), pairFirst[i]);
            sendB(2'd0, 5'(20 + i), pairSecond[i]);
            checkOutput("pair_bresp", 32'(dsp_BRESP_o), 32'(pairExpect[i]));
        end
        tick();

        // Fill order queue, stall downstream, then drain back-to-back
        dsp_BREADY_i = 3'b000;
        for (int i = 0; i < 8; i++) begin
            pushAw(1'b0);
        end
        checkOutput("full_after8", 32'(AW_order_full_o), 32'd1);
        pushAw(1'b1);
        checkOutput("full_after9", 32'(AW_order_full_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
            expectResp(2'd0, 5'(10 + i), 2'(i));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    sendB(2'd0, 5'(10 + i), 2'(i));
                end
            end
            begin
                tick();
                checkOutput("stall_bready", 32'(s_BREADY_o), 32'd0);
                checkOutput("stall_bvalid", 32'(dsp_BVALID_o), 32'b001);
                repeat (5) tick();
                checkOutput("stall_bready_late", 32'(s_BREADY_o), 32'd0);
                checkOutput("stall_bid", 32'(dsp_BID_o), 32'd10);
                dsp_BREADY_i = 3'b111;
                for (int k = 0; k < 8; k++) begin
                    @(negedge ACLK_i);
                    checkOutput("b2b_bvalid", 32'(dsp_BVALID_o), 32'b001);
                end
            end
        join
        repeat (2) tick();
        checkOutput("drain_empty", 32'(s_BREADY_o), 32'd0);
        checkOutput("drain_full", 32'(AW_order_full_o), 32'd0);

        // Reset while merging with entries still queued
        pushAw(1'b1);
        pushAw(1'b0);
        pushAw(1'b0);
        pushAw(1'b0);
        sendB(2'd0, 5'd1, 2'b00);
        ARESETn_i = 1'b0;
        #1;
        checkOutput("midrst_bready", 32'(s_BREADY_o), 32'd0);
        tick();
        checkOutput("midrst_outs", 32'({dsp_BVALID_o, dsp_BID_o, dsp_BRESP_o, AW_order_full_o}), 32'd0);
        tick();
        ARESETn_i = 1'b1;
        tick();
        checkOutput("postrst_empty", 32'(s_BREADY_o), 32'd0);
        pushAw(1'b0);
        expectResp(2'd1, 5'd9, 2'b01);
        sendB(2'd1, 5'd9, 2'b01);
        checkOutput("postrst_bvalid", 32'(dsp_BVALID_o), 32'b010);
        checkOutput("postrst_bresp", 32'(dsp_BRESP_o), 32'b01);
        tick();

        // Out-of-range master is dropped, next response unaffected
        pushAw(1'b0);
        pushAw(1'b0);
        sendB(2'd3, 5'd4, 2'b00);
        checkOutput("badmst_bvalid", 32'(dsp_BVALID_o), 32'd0);
        expectResp(2'd2, 5'd6, 2'b11);
        sendB(2'd2, 5'd6, 2'b11);
        checkOutput("after_bad_bvalid", 32'(dsp_BVALID_o), 32'b100);
        checkOutput("after_bad_bid", 32'(dsp_BID_o), 32'd6);
    endtask

    // Main sequence with bounded drain of the scoreboard
    initial begin
        int drainCycles = 0;
        applyStimulus();
        while (sb.size() != 0 && drainCycles < 50) begin
            tick();
            drainCycles++;
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
